// File: rtl/menu_controller_pkg.sv
// Shared types, widths and helpers for the greenhouse menu controller.
// Holds the page encoding, field widths and the wrap limits for hours and minutes.
package menu_pkg;

   localparam int unsigned PAGE_W   = 4;
   localparam int unsigned TEMP_W   = 12;
   localparam int unsigned HUM_W    = 8;
   localparam int unsigned HOUR_W   = 5;
   localparam int unsigned MIN_W    = 6;
   localparam int unsigned HOUR_MAX = 23;
   localparam int unsigned MIN_MAX  = 59;

   typedef enum logic [PAGE_W-1:0] {
      PG_HOME   = 4'd0,
      PG_TEMP   = 4'd1,
      PG_HUM    = 4'd2,
      PG_TIME_H = 4'd3,
      PG_TIME_M = 4'd4,
      PG_SUN_H  = 4'd5,
      PG_SUN_M  = 4'd6
   } page_e;

   typedef struct packed {
      logic [HOUR_W-1:0] hours;
      logic [MIN_W-1:0]  minutes;
   } hhmm_t;

   // Counter width able to hold 0 .. n-1.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic page_e next_page(input page_e p);
      page_e r;
      case (p)
         PG_HOME:   r = PG_TEMP;
         PG_TEMP:   r = PG_HUM;
         PG_HUM:    r = PG_TIME_H;
         PG_TIME_H: r = PG_TIME_M;
         PG_TIME_M: r = PG_SUN_H;
         PG_SUN_H:  r = PG_SUN_M;
         default:   r = PG_HOME;
      endcase
      return r;
   endfunction

   // One up/down step on a field that wraps between 0 and lim.
   function automatic logic [7:0] wrap_step(input logic [7:0] val, input logic [7:0] lim,
                                            input logic up);
      logic [7:0] r;
      if (up) r = (val == lim) ? 8'd0 : val + 8'd1;
      else    r = (val == 8'd0) ? lim : val - 8'd1;
      return r;
   endfunction

endpackage

// File: rtl/menu_controller_if.sv
// Button, RTC and setpoint signals between the menu controller and its neighbours.
// slave is the controller side; master is the debouncer/RTC/display side.
interface menu_controller_if;
   import menu_pkg::*;

   logic                KEY_NEXT;
   logic                KEY_UP;
   logic                KEY_DOWN;
   logic [HOUR_W-1:0]   TIME_HOURS;
   logic [MIN_W-1:0]    TIME_MINUTES;
   logic [PAGE_W-1:0]   MENU_STATE;
   logic [TEMP_W-1:0]   SET_TEMP_F;
   logic [HUM_W-1:0]    SET_HUM;
   logic [HOUR_W-1:0]   SUNRISE_HOURS;
   logic [MIN_W-1:0]    SUNRISE_MINUTES;
   logic [HOUR_W-1:0]   EDIT_HOURS;
   logic [MIN_W-1:0]    EDIT_MINUTES;
   logic                TIME_LOAD;

   modport master (
      output KEY_NEXT, KEY_UP, KEY_DOWN, TIME_HOURS, TIME_MINUTES,
      input  MENU_STATE, SET_TEMP_F, SET_HUM, SUNRISE_HOURS, SUNRISE_MINUTES,
             EDIT_HOURS, EDIT_MINUTES, TIME_LOAD
   );

   modport slave (
      input  KEY_NEXT, KEY_UP, KEY_DOWN, TIME_HOURS, TIME_MINUTES,
      output MENU_STATE, SET_TEMP_F, SET_HUM, SUNRISE_HOURS, SUNRISE_MINUTES,
             EDIT_HOURS, EDIT_MINUTES, TIME_LOAD
   );

endinterface

// File: rtl/menu_controller_key_repeat.sv
// Rising-edge detect and hold-to-repeat for one debounced key.
// step_c fires on the edge, then REPEAT_DELAY cycles later, then every REPEAT_RATE cycles.
module key_repeat
   import menu_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY = 25_000_000,
   parameter int unsigned REPEAT_RATE  = 5_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   input  logic clear,
   output logic step_c,
   output logic edge_c
);

   localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

   logic             key_q;
   logic             armed_q;
   logic             rpt_q;
   logic [CNT_W-1:0] cnt_q;
   logic             fire_c;

   // A clear both suppresses the step and disarms repeating until the next fresh edge.
   always_comb begin
      edge_c = key & ~key_q;
      fire_c = armed_q & key & ~clear & (cnt_q == (rpt_q ? RATE_LAST : DELAY_LAST));
      step_c = (edge_c & ~clear) | fire_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q   <= 1'b0;
         armed_q <= 1'b0;
         rpt_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         key_q <= key;
         if (clear || !key) begin
            armed_q <= 1'b0;
            rpt_q   <= 1'b0;
            cnt_q   <= '0;
         end else if (edge_c) begin
            armed_q <= 1'b1;
            rpt_q   <= 1'b0;
            cnt_q   <= '0;
         end else if (fire_c) begin
            rpt_q <= 1'b1;
            cnt_q <= '0;
         end else if (armed_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/menu_controller.sv
// Menu page sequencer and owner of the user setpoints for the greenhouse display.
// Turns NEXT/UP/DOWN levels into MENU_STATE, field edits, staged RTC time and TIME_LOAD.
module menu_controller
   import menu_pkg::*;
#(
   parameter int unsigned TEMP_MIN          = 50,
   parameter int unsigned TEMP_MAX          = 99,
   parameter int unsigned TEMP_DEFAULT      = 72,
   parameter int unsigned HUM_MIN           = 20,
   parameter int unsigned HUM_MAX           = 90,
   parameter int unsigned HUM_DEFAULT       = 60,
   parameter int unsigned SUNRISE_H_DEFAULT = 6,
   parameter int unsigned REPEAT_DELAY      = 25_000_000,
   parameter int unsigned REPEAT_RATE       = 5_000_000,
   parameter int unsigned IDLE_TIMEOUT      = 500_000_000
) (
   input logic              CLOCK_50,
   input logic              RESET_N,
   menu_controller_if.slave bus
);

   localparam int unsigned IDLE_W = cnt_width(IDLE_TIMEOUT);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

   page_e              page_q, page_d;
   logic               next_q;
   logic [IDLE_W-1:0]  idle_q;
   logic               next_edge_c, clear_c, any_edge_c, timeout_c, step_ok_c;
   logic               up_step_c, dn_step_c, up_edge_c, dn_edge_c;

   logic [TEMP_W-1:0]  temp_q, temp_d;
   logic [HUM_W-1:0]   hum_q, hum_d;
   hhmm_t              edit_q, edit_d;
   hhmm_t              sun_q, sun_d;
   logic               load_q, load_d;

   assign next_edge_c = bus.KEY_NEXT & ~next_q;
   assign clear_c     = (bus.KEY_UP & bus.KEY_DOWN) | next_edge_c;

   key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
      .clk(CLOCK_50), .rst_n(RESET_N), .key(bus.KEY_UP), .clear(clear_c),
      .step_c(up_step_c), .edge_c(up_edge_c)
   );

   key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dn (
      .clk(CLOCK_50), .rst_n(RESET_N), .key(bus.KEY_DOWN), .clear(clear_c),
      .step_c(dn_step_c), .edge_c(dn_edge_c)
   );

   // A key edge on the timeout cycle restarts the idle window instead of timing out.
   assign any_edge_c = next_edge_c | up_edge_c | dn_edge_c;
   assign timeout_c  = (page_q != PG_HOME) && (idle_q == IDLE_LAST) && !any_edge_c;

   // State register: page, NEXT edge sample and idle counter.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         page_q <= PG_HOME;
         next_q <= 1'b0;
         idle_q <= '0;
      end else begin
         page_q <= page_d;
         next_q <= bus.KEY_NEXT;
         if (any_edge_c || (page_d != page_q) || (page_q == PG_HOME)) idle_q <= '0;
         else                                                          idle_q <= idle_q + IDLE_W'(1);
      end
   end

   // Next page.
   always_comb begin
      page_d = page_q;
      if (page_q > PG_SUN_M)  page_d = PG_HOME;
      else if (next_edge_c)   page_d = next_page(page_q);
      else if (timeout_c)     page_d = PG_HOME;
   end

   // Field updates, edit staging and the RTC load strobe; steps are dropped on a page change.
   always_comb begin
      temp_d    = temp_q;
      hum_d     = hum_q;
      edit_d    = edit_q;
      sun_d     = sun_q;
      load_d    = (page_q == PG_TIME_M) && (page_d == PG_SUN_H);
      step_ok_c = (up_step_c | dn_step_c) && (page_d == page_q);

      if ((page_d == PG_TIME_H) && (page_q != PG_TIME_H))
         edit_d = '{hours: bus.TIME_HOURS, minutes: bus.TIME_MINUTES};

      if (step_ok_c) begin
         case (page_q)
            PG_TEMP: begin
               if (up_step_c) begin
                  if (temp_q < TEMP_W'(TEMP_MAX)) temp_d = temp_q + TEMP_W'(1);
               end else begin
                  if (temp_q > TEMP_W'(TEMP_MIN)) temp_d = temp_q - TEMP_W'(1);
               end
            end
            PG_HUM: begin
               if (up_step_c) begin
                  if (hum_q < HUM_W'(HUM_MAX)) hum_d = hum_q + HUM_W'(1);
               end else begin
                  if (hum_q > HUM_W'(HUM_MIN)) hum_d = hum_q - HUM_W'(1);
               end
            end
            PG_TIME_H: edit_d.hours   = HOUR_W'(wrap_step(8'(edit_q.hours), 8'(HOUR_MAX), up_step_c));
            PG_TIME_M: edit_d.minutes = MIN_W'(wrap_step(8'(edit_q.minutes), 8'(MIN_MAX), up_step_c));
            PG_SUN_H:  sun_d.hours    = HOUR_W'(wrap_step(8'(sun_q.hours), 8'(HOUR_MAX), up_step_c));
            PG_SUN_M:  sun_d.minutes  = MIN_W'(wrap_step(8'(sun_q.minutes), 8'(MIN_MAX), up_step_c));
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         temp_q <= TEMP_W'(TEMP_DEFAULT);
         hum_q  <= HUM_W'(HUM_DEFAULT);
         edit_q <= '0;
         sun_q  <= '{hours: HOUR_W'(SUNRISE_H_DEFAULT), minutes: '0};
         load_q <= 1'b0;
      end else begin
         temp_q <= temp_d;
         hum_q  <= hum_d;
         edit_q <= edit_d;
         sun_q  <= sun_d;
         load_q <= load_d;
      end
   end

   assign bus.MENU_STATE      = page_q;
   assign bus.SET_TEMP_F      = temp_q;
   assign bus.SET_HUM         = hum_q;
   assign bus.SUNRISE_HOURS   = sun_q.hours;
   assign bus.SUNRISE_MINUTES = sun_q.minutes;
   assign bus.EDIT_HOURS      = edit_q.hours;
   assign bus.EDIT_MINUTES    = edit_q.minutes;
   assign bus.TIME_LOAD       = load_q;

endmodule

// File: tb/tb_menu_controller.sv
// Scoreboard bench for menu_controller: a cycle-level behavioural model predicts every output,
// a monitor compares each cycle, plus directed checks of the documented scenarios.
module tb_menu_controller;

   localparam int DLY = 8;
   localparam int RATE = 3;
   localparam int IDLE = 50;

   typedef struct packed {
      logic [3:0]  ms;
      logic [11:0] temp;
      logic [7:0]  hum;
      logic [4:0]  sh;
      logic [5:0]  sm;
      logic [4:0]  eh;
      logic [5:0]  em;
      logic        ld;
   } obs_t;

   logic CLOCK_50 = 1'b0;
   logic RESET_N  = 1'b0;

   menu_controller_if bus ();

   menu_controller #(
      .TEMP_MIN(50), .TEMP_MAX(99), .TEMP_DEFAULT(72),
      .HUM_MIN(20), .HUM_MAX(90), .HUM_DEFAULT(60),
      .SUNRISE_H_DEFAULT(6),
      .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .IDLE_TIMEOUT(IDLE)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int   n_vec = 0;
   int   n_err = 0;
   obs_t exp_q[$];
   obs_t mon_e, mon_a;
   int   cur_th, cur_tm;

   // Reference model state (plain integers, cycle-indexed).
   int m_t, m_page, m_temp, m_hum, m_sh, m_sm, m_eh, m_em, m_load, m_quiet;
   int m_ustart, m_dstart;
   bit m_pn, m_pu, m_pd, m_uarm, m_darm;

   function automatic obs_t sample();
      return '{ms: bus.MENU_STATE, temp: bus.SET_TEMP_F, hum: bus.SET_HUM,
                sh: bus.SUNRISE_HOURS, sm: bus.SUNRISE_MINUTES,
                eh: bus.EDIT_HOURS, em: bus.EDIT_MINUTES, ld: bus.TIME_LOAD};
   endfunction

   function automatic obs_t m_obs();
      return '{ms: 4'(m_page), temp: 12'(m_temp), hum: 8'(m_hum), sh: 5'(m_sh), sm: 6'(m_sm),
               eh: 5'(m_eh), em: 6'(m_em), ld: 1'(m_load)};
   endfunction

   task automatic m_reset();
      m_page = 0; m_temp = 72; m_hum = 60; m_sh = 6; m_sm = 0; m_eh = 0; m_em = 0; m_load = 0;
      m_pn = 0; m_pu = 0; m_pd = 0; m_uarm = 0; m_darm = 0; m_quiet = m_t;
   endtask

   // Steps at the edge, then at start+DLY, start+DLY+RATE, ... while held and not cleared.
   task automatic key_model(input bit k, input bit kedge, input bit clr,
                            inout bit arm, inout int start, output bit st);
      st = 0;
      if (clr || !k) arm = 0;
      else if (kedge) begin arm = 1; start = m_t; st = 1; end
      else if (arm && (m_t - start) >= DLY && ((m_t - start - DLY) % RATE) == 0) st = 1;
   endtask

   task automatic m_clock(input bit n, input bit u, input bit d, input int th, input int tm);
      bit ne, ue, de, clr, ust, dst, tmo;
      int np, dlt;
      ne = n && !m_pn; ue = u && !m_pu; de = d && !m_pd;
      clr = (u && d) || ne;
      key_model(u, ue, clr, m_uarm, m_ustart, ust);
      key_model(d, de, clr, m_darm, m_dstart, dst);
      tmo = (m_page != 0) && !(ne || ue || de) && (m_t - m_quiet == IDLE);
      np = ne ? (m_page + 1) % 7 : (tmo ? 0 : m_page);
      m_load = (m_page == 4 && np == 5) ? 1 : 0;
      if (np == 3 && m_page != 3) begin m_eh = th; m_em = tm; end
      if ((ust || dst) && np == m_page) begin
         dlt = ust ? 1 : -1;
         case (m_page)
            1: m_temp = (m_temp + dlt > 99) ? 99 : ((m_temp + dlt < 50) ? 50 : m_temp + dlt);
            2: m_hum  = (m_hum + dlt > 90) ? 90 : ((m_hum + dlt < 20) ? 20 : m_hum + dlt);
            3: m_eh = (m_eh + dlt + 24) % 24;
            4: m_em = (m_em + dlt + 60) % 60;
            5: m_sh = (m_sh + dlt + 24) % 24;
            6: m_sm = (m_sm + dlt + 60) % 60;
            default: ;
         endcase
      end
      if (ne || ue || de || np != m_page) m_quiet = m_t;
      m_page = np; m_pn = n; m_pu = u; m_pd = d;
      m_t++;
   endtask

   // Drive one cycle of inputs, predict its outcome, return just after the clock edge.
   task automatic cyc(input bit n, input bit u, input bit d);
      @(negedge CLOCK_50);
      bus.KEY_NEXT = n; bus.KEY_UP = u; bus.KEY_DOWN = d;
      bus.TIME_HOURS = 5'(cur_th); bus.TIME_MINUTES = 6'(cur_tm);
      m_clock(n, u, d, cur_th, cur_tm);
      exp_q.push_back(m_obs());
      @(posedge CLOCK_50);
      #2;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always begin
      @(posedge CLOCK_50);
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_a = sample();
         n_vec++;
         if (mon_a !== mon_e) begin
            n_err++;
            $display("FAIL scoreboard @%0t: got page=%0d temp=%0d hum=%0d sun=%0d:%0d edit=%0d:%0d load=%0d, expected page=%0d temp=%0d hum=%0d sun=%0d:%0d edit=%0d:%0d load=%0d",
                     $time, mon_a.ms, mon_a.temp, mon_a.hum, mon_a.sh, mon_a.sm, mon_a.eh, mon_a.em, mon_a.ld,
                     mon_e.ms, mon_e.temp, mon_e.hum, mon_e.sh, mon_e.sm, mon_e.eh, mon_e.em, mon_e.ld);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit rn, ru, rd, load_seen;
      int rate;
      m_t = 0;
      cur_th = 0; cur_tm = 59;
      bus.KEY_NEXT = 0; bus.KEY_UP = 0; bus.KEY_DOWN = 0;
      bus.TIME_HOURS = 5'(cur_th); bus.TIME_MINUTES = 6'(cur_tm);
      m_reset();
      repeat (3) @(posedge CLOCK_50);
      #1;
      chk("reset MENU_STATE", bus.MENU_STATE, 0);
      chk("reset SET_TEMP_F", bus.SET_TEMP_F, 72);
      chk("reset SET_HUM", bus.SET_HUM, 60);
      chk("reset SUNRISE_HOURS", bus.SUNRISE_HOURS, 6);
      chk("reset TIME_LOAD", bus.TIME_LOAD, 0);
      @(negedge CLOCK_50);
      RESET_N = 1;

      // Page walk.
      for (int i = 1; i <= 7; i++) begin
         cyc(1, 0, 0);
         chk("next page", bus.MENU_STATE, i % 7);
         cyc(0, 0, 0);
      end

      // TEMP saturation under auto-repeat.
      cyc(1, 0, 0); cyc(0, 0, 0);
      repeat (25) begin cyc(0, 1, 0); cyc(0, 0, 0); end
      chk("temp after pulses", bus.SET_TEMP_F, 97);
      cyc(0, 1, 0);
      chk("temp at edge", bus.SET_TEMP_F, 98);
      repeat (7) cyc(0, 1, 0);
      chk("temp before first repeat", bus.SET_TEMP_F, 98);
      cyc(0, 1, 0);
      chk("temp first repeat", bus.SET_TEMP_F, 99);
      repeat (3) cyc(0, 1, 0);
      chk("temp saturated", bus.SET_TEMP_F, 99);
      repeat (8) cyc(0, 1, 0);
      chk("temp held max", bus.SET_TEMP_F, 99);
      cyc(0, 0, 0);

      // Staged time edit and load.
      cyc(1, 0, 0); cyc(0, 0, 0);
      cyc(1, 0, 0);
      chk("edit hours copied", bus.EDIT_HOURS, 0);
      chk("edit minutes copied", bus.EDIT_MINUTES, 59);
      cyc(0, 0, 0);
      cyc(0, 0, 1);
      chk("edit hours wrap down", bus.EDIT_HOURS, 23);
      cyc(0, 0, 0);
      cyc(1, 0, 0); cyc(0, 0, 0);
      cyc(0, 1, 0);
      chk("edit minutes wrap up", bus.EDIT_MINUTES, 0);
      cyc(0, 0, 0);
      cyc(1, 0, 0);
      chk("load strobe", bus.TIME_LOAD, 1);
      chk("page after load", bus.MENU_STATE, 5);
      cyc(0, 0, 0);
      chk("load one cycle", bus.TIME_LOAD, 0);

      // Timeout abandons the edit.
      repeat (2) begin cyc(1, 0, 0); cyc(0, 0, 0); end
      repeat (3) begin cyc(1, 0, 0); cyc(0, 0, 0); end
      cyc(0, 0, 1);
      chk("edit hours wrap again", bus.EDIT_HOURS, 23);
      load_seen = 0;
      repeat (49) begin cyc(0, 0, 0); if (bus.TIME_LOAD) load_seen = 1; end
      chk("page before timeout", bus.MENU_STATE, 3);
      cyc(0, 0, 0);
      if (bus.TIME_LOAD) load_seen = 1;
      chk("page at timeout", bus.MENU_STATE, 0);
      chk("no load on timeout", load_seen, 0);

      // Simultaneous keys and NEXT priority on HUM.
      repeat (2) begin cyc(1, 0, 0); cyc(0, 0, 0); end
      repeat (30) cyc(0, 1, 1);
      chk("hum with both keys", bus.SET_HUM, 60);
      cyc(0, 0, 0);
      cyc(1, 1, 0);
      chk("next beats step page", bus.MENU_STATE, 3);
      chk("next beats step hum", bus.SET_HUM, 60);
      cyc(0, 0, 0);

      // Asynchronous reset while repeating on TEMP.
      repeat (5) begin cyc(1, 0, 0); cyc(0, 0, 0); end
      repeat (15) cyc(0, 1, 0);
      #1;
      RESET_N = 0;
      #1;
      chk("async rst MENU_STATE", bus.MENU_STATE, 0);
      chk("async rst SET_TEMP_F", bus.SET_TEMP_F, 72);
      chk("async rst SET_HUM", bus.SET_HUM, 60);
      chk("async rst SUNRISE", {27'd0, bus.SUNRISE_HOURS, bus.SUNRISE_MINUTES}, 6 * 64);
      chk("async rst EDIT", {21'd0, bus.EDIT_HOURS, bus.EDIT_MINUTES}, 0);
      chk("async rst TIME_LOAD", bus.TIME_LOAD, 0);
      bus.KEY_NEXT = 0; bus.KEY_UP = 0; bus.KEY_DOWN = 0;
      m_reset();
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      RESET_N = 1;

      // Randomized segments with varying key activity.
      rn = 0; ru = 0; rd = 0;
      for (int seg = 0; seg < 16; seg++) begin
         rate = $urandom_range(2, 40);
         repeat (200) begin
            if ($urandom_range(0, rate) == 0) ru = !ru;
            if ($urandom_range(0, rate) == 0) rd = !rd;
            if ($urandom_range(0, rate * 3) == 0) rn = !rn;
            cur_th = $urandom_range(0, 23);
            cur_tm = $urandom_range(0, 59);
            cyc(rn, ru, rd);
         end
      end
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      repeat (2) @(posedge CLOCK_50);
      #2;
      chk("scoreboard drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
